// File: rtl/mul4_seq_if.sv
// Handshake bundle for mul4_seq: operand request from the controller, product/status back.
interface mul4_seq_if;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
    logic       busy;
    logic       done;

    modport master (output start, a, b, input p, busy, done);
    modport slave  (input start, a, b, output p, busy, done);
endinterface

// File: rtl/mul4_seq.sv
// Sequential 4x4 unsigned shift-and-add multiplier with start/busy/done handshake.
// Optional build macro MUL4_EARLY_TERM_EN: finish CALC once remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one add+shift step per cycle on {H, L}
// DONE  | p just updated, done pulse; start here chains the next multiply
module mul4_seq (
    input  logic     clk,
    input  logic     rst_n,
    mul4_seq_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t     state, state_nxt;
    logic [3:0] a_q, a_nxt;
    logic [3:0] h_q, h_nxt;
    logic [3:0] l_q, l_nxt;
    logic [2:0] cnt_q, cnt_nxt;
    logic [7:0] p_q, p_nxt;
    logic       busy_q, done_q;

    logic [3:0] sum;
    logic       c;
    logic [7:0] hl_sh;
    logic [7:0] hl_fin;
    logic [2:0] cnt_inc;
    logic       last;

    assign {c, sum} = {1'b0, h_q} + {1'b0, (l_q[0] ? a_q : 4'd0)};
    assign hl_sh    = {c, sum, l_q[3:1]};
    assign cnt_inc  = cnt_q + 3'd1;

`ifdef MUL4_EARLY_TERM_EN
    // Low (4 - steps) bits of the shifted L are the multiplier bits still to process.
    logic [3:0] rem_mask;
    assign rem_mask = 4'hF >> cnt_inc;
    assign last     = (cnt_inc == 3'd4) || ((hl_sh[3:0] & rem_mask) == 4'd0);
    assign hl_fin   = hl_sh >> (3'd4 - cnt_inc);
`else
    assign last     = (cnt_q == 3'd3);
    assign hl_fin   = hl_sh;
`endif

    always_comb begin
        state_nxt = state;
        a_nxt     = a_q;
        h_nxt     = h_q;
        l_nxt     = l_q;
        cnt_nxt   = cnt_q;
        p_nxt     = p_q;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_nxt     = bus.a;
                    l_nxt     = bus.b;
                    h_nxt     = 4'd0;
                    cnt_nxt   = 3'd0;
                    state_nxt = CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            CALC: begin
                cnt_nxt = cnt_inc;
                if (last) begin
                    {h_nxt, l_nxt} = hl_fin;
                    p_nxt          = hl_fin;
                    state_nxt      = DONE;
                end else begin
                    {h_nxt, l_nxt} = hl_sh;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_q    <= 4'd0;
            h_q    <= 4'd0;
            l_q    <= 4'd0;
            cnt_q  <= 3'd0;
            p_q    <= 8'h00;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            a_q    <= a_nxt;
            h_q    <= h_nxt;
            l_q    <= l_nxt;
            cnt_q  <= cnt_nxt;
            p_q    <= p_nxt;
            busy_q <= (state_nxt == CALC);
            done_q <= (state_nxt == DONE);
        end
    end

    assign bus.p    = p_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_mul4_seq.sv
// Directed self-checking bench for mul4_seq; expectations follow the build macro MUL4_EARLY_TERM_EN.
module tb_mul4_seq;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    mul4_seq_if bus ();

    mul4_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected number of CALC cycles for multiplier vb.
    function automatic int exp_cycles(input logic [3:0] vb);
`ifdef MUL4_EARLY_TERM_EN
        if (vb[3]) return 4;
        if (vb[2]) return 3;
        if (vb[1]) return 2;
        return 1;
`else
        return 4;
`endif
    endfunction

    // Issue one multiply from a negedge; returns at the negedge inside the done cycle.
    task automatic run_mul(input logic [3:0] ta, input logic [3:0] tb_v,
                           output logic [7:0] rp, output int nbusy, output int didx);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_v;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        nbusy = 0;
        didx  = -1;
        rp    = 8'hxx;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus.busy) nbusy++;
            if (bus.done) begin
                didx = i;
                rp   = bus.p;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = 4'd0;
        bus.b     = 4'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.p !== 8'h00) begin errors++; $display("FAIL reset_p got=%h want=00", bus.p); end
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL reset_flags got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_max;
        logic [7:0] rp;
        int nb, di, extra;
        run_mul(4'd15, 4'd15, rp, nb, di);
        checks++;
        if (nb !== exp_cycles(4'd15)) begin errors++; $display("FAIL max_busy got=%0d want=%0d", nb, exp_cycles(4'd15)); end
        checks++;
        if (di !== exp_cycles(4'd15) + 1) begin errors++; $display("FAIL max_done_at got=%0d want=%0d", di, exp_cycles(4'd15) + 1); end
        checks++;
        if (rp !== 8'hE1) begin errors++; $display("FAIL max_p got=%h want=e1", rp); end
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.done) extra++;
            checks++;
            if (bus.p !== 8'hE1) begin errors++; $display("FAIL max_hold_p cyc=%0d got=%h want=e1", i, bus.p); end
        end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL max_single_done got=%0d extra want=0", extra); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] rp;
        int nb, di;
        run_mul(4'd7, 4'd5, rp, nb, di);
        checks++;
        if (rp !== 8'h23) begin errors++; $display("FAIL b2b_first_p got=%h want=23", rp); end
        run_mul(4'd0, 4'd9, rp, nb, di);
        checks++;
        if (rp !== 8'h00) begin errors++; $display("FAIL b2b_second_p got=%h want=00", rp); end
        checks++;
        if (di !== 5) begin errors++; $display("FAIL b2b_done_spacing got=%0d want=5", di); end
        checks++;
        if (nb !== exp_cycles(4'd9)) begin errors++; $display("FAIL b2b_busy got=%0d want=%0d", nb, exp_cycles(4'd9)); end
        @(negedge clk);
    endtask

    task automatic test_start_ignored;
        int nc, nb, dones, didx;
        logic [7:0] rp;
        nc = exp_cycles(4'd2);
        bus.start = 1'b1;
        bus.a     = 4'd3;
        bus.b     = 4'd2;
        @(posedge clk);
        #1;
        bus.a = 4'd15;
        bus.b = 4'd15;
        nb = 0; dones = 0; didx = -1; rp = 8'hxx;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i >= nc - 1) bus.start = 1'b0;
            if (bus.busy) nb++;
            if (bus.done) begin
                dones++;
                if (didx < 0) begin didx = i; rp = bus.p; end
            end
        end
        checks++;
        if (rp !== 8'h06) begin errors++; $display("FAIL ignore_p got=%h want=06", rp); end
        checks++;
        if (didx !== nc + 1) begin errors++; $display("FAIL ignore_done_at got=%0d want=%0d", didx, nc + 1); end
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d want=1", dones); end
        checks++;
        if (nb !== nc) begin errors++; $display("FAIL ignore_busy got=%0d want=%0d", nb, nc); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] rp;
        int nb, di, dones;
        bus.start = 1'b1;
        bus.a     = 4'd9;
        bus.b     = 4'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy got=%b want=1", bus.busy); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.p !== 8'h00) begin errors++; $display("FAIL midrst_p got=%h want=00", bus.p); end
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL midrst_flags got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL midrst_no_done got=%0d active cycles want=0", dones); end
        run_mul(4'd9, 4'd9, rp, nb, di);
        checks++;
        if (rp !== 8'h51) begin errors++; $display("FAIL midrst_fresh_p got=%h want=51", rp); end
        @(negedge clk);
    endtask

    task automatic test_early_term;
        logic [7:0] rp;
        int nb, di;
        run_mul(4'd13, 4'd1, rp, nb, di);
        checks++;
        if (nb !== exp_cycles(4'd1)) begin errors++; $display("FAIL et_b1_busy got=%0d want=%0d", nb, exp_cycles(4'd1)); end
        checks++;
        if (di !== exp_cycles(4'd1) + 1) begin errors++; $display("FAIL et_b1_done_at got=%0d want=%0d", di, exp_cycles(4'd1) + 1); end
        checks++;
        if (rp !== 8'h0D) begin errors++; $display("FAIL et_b1_p got=%h want=0d", rp); end
        run_mul(4'd13, 4'd8, rp, nb, di);
        checks++;
        if (nb !== 4) begin errors++; $display("FAIL et_b8_busy got=%0d want=4", nb); end
        checks++;
        if (rp !== 8'h68) begin errors++; $display("FAIL et_b8_p got=%h want=68", rp); end
        run_mul(4'd5, 4'd0, rp, nb, di);
        checks++;
        if (nb !== exp_cycles(4'd0)) begin errors++; $display("FAIL et_b0_busy got=%0d want=%0d", nb, exp_cycles(4'd0)); end
        checks++;
        if (rp !== 8'h00) begin errors++; $display("FAIL et_b0_p got=%h want=00", rp); end
        @(negedge clk);
    endtask

    task automatic test_sweep;
        logic [7:0] rp, want;
        int nb, di, dones;
        dones = 0;
        for (int i = 0; i < 256; i++) begin
            run_mul(i[7:4], i[3:0], rp, nb, di);
            want = 8'(i[7:4]) * 8'(i[3:0]);
            if (di > 0) dones++;
            checks++;
            if (rp !== want || nb !== exp_cycles(i[3:0])) begin
                errors++;
                $display("FAIL sweep a=%0d b=%0d got p=%h busy=%0d want p=%h busy=%0d",
                         i[7:4], i[3:0], rp, nb, want, exp_cycles(i[3:0]));
            end
        end
        checks++;
        if (dones !== 256) begin errors++; $display("FAIL sweep_done_count got=%0d want=256", dones); end
        @(negedge clk);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_max();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        test_early_term();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
